// File: rtl/tl_pkg.sv
// tl_pkg: shared TileLink field widths, opcodes and responder state encoding.
package tl_pkg;
  localparam int ADDR_W = 31;
  localparam int SRC_W  = 5;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;
  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_HINT        = 3'd5;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_GET, ST_PUT, ST_RESP} state_t;
  // Index of the final beat; size 7 is refused outright, so it is answered as one beat.
  function automatic logic [2:0] last_beat(input logic [2:0] size);
    return size == 3'd4 ? 3'd1 : size == 3'd5 ? 3'd3 : size == 3'd6 ? 3'd7 : 3'd0;
  endfunction
endpackage

// File: rtl/tl_ram_responder_if.sv
// tl_ram_responder_if: TileLink A/D channel bundle between a requester and the RAM responder.
interface tl_ram_responder_if;
  import tl_pkg::*;
  logic              a_ready;
  logic              a_valid;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [MASK_W-1:0] a_mask;
  logic [DATA_W-1:0] a_data;
  logic              a_corrupt;
  logic              d_ready;
  logic              d_valid;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_denied;
  logic [DATA_W-1:0] d_data;
  logic              d_corrupt;
  modport master (
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready
  );
  modport slave (
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready
  );
endinterface

// File: rtl/tl_responder_mem.sv
// tl_responder_mem: 64-bit word store with one combinational read port and one byte-masked write port.
module tl_responder_mem
  import tl_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [AW-1:0]     rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [AW-1:0]     wr_idx_i,
  input  logic [MASK_W-1:0] wmask_i,
  input  logic [DATA_W-1:0] wdata_i
);
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  assign rd_data_o = mem_q[rd_idx_i];
  always_ff @(posedge clk) begin
    for (int i = 0; i < MASK_W; i++)
      if (we_i && wmask_i[i]) mem_q[wr_idx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
  end
endmodule

// File: rtl/tl_ram_responder.sv
// tl_ram_responder: single-outstanding TileLink-UL RAM slave with registered D channel.
module tl_ram_responder
  import tl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 31'h0800_0000,
  parameter int DEPTH_WORDS = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              auto_in_a_ready,
  input  logic              auto_in_a_valid,
  input  logic [2:0]        auto_in_a_bits_opcode,
  input  logic [2:0]        auto_in_a_bits_param,
  input  logic [2:0]        auto_in_a_bits_size,
  input  logic [SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [MASK_W-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0] auto_in_a_bits_data,
  input  logic              auto_in_a_bits_corrupt,
  input  logic              auto_in_d_ready,
  output logic              auto_in_d_valid,
  output logic [2:0]        auto_in_d_bits_opcode,
  output logic [1:0]        auto_in_d_bits_param,
  output logic [2:0]        auto_in_d_bits_size,
  output logic [SRC_W-1:0]  auto_in_d_bits_source,
  output logic              auto_in_d_bits_sink,
  output logic              auto_in_d_bits_denied,
  output logic [DATA_W-1:0] auto_in_d_bits_data,
  output logic              auto_in_d_bits_corrupt
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state_q, state_d;
  logic [2:0] beat_q, beat_d, last_q, last_d, op_q, op_d, size_q, size_d;
  logic [AW-1:0] idx_q, idx_d, a_idx, rd_idx, wr_idx;
  logic [SRC_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] data_q, data_d, rd_data;
  logic valid_q, valid_d, den_q, den_d, cor_q, cor_d;
  logic a_fire, d_fire, is_put, is_hint, is_get, deny_now, we;
  logic [31:0] a_ext, base_ext;
  logic unused_a_param;
  assign unused_a_param = ^auto_in_a_bits_param;
  assign a_idx    = auto_in_a_bits_address[AW+2:3];
  assign a_ext    = {1'b0, auto_in_a_bits_address};
  assign base_ext = {1'b0, BASE_ADDR};
  assign is_put   = auto_in_a_bits_opcode == A_PUT_FULL || auto_in_a_bits_opcode == A_PUT_PARTIAL;
  assign is_hint  = auto_in_a_bits_opcode == A_HINT;
  assign is_get   = auto_in_a_bits_opcode == A_GET;
  assign deny_now = !(is_put || is_hint || is_get) || auto_in_a_bits_size == 3'd7
                 || a_ext < base_ext || a_ext >= base_ext + 32'(8 * DEPTH_WORDS)
                 || (auto_in_a_bits_address & ((31'd1 << auto_in_a_bits_size) - 31'd1)) != '0;
  assign auto_in_a_ready = state_q == ST_IDLE || state_q == ST_PUT;
  assign a_fire = auto_in_a_valid && auto_in_a_ready;
  assign d_fire = valid_q && auto_in_d_ready;
  // Reads look one beat ahead so the next D word is ready to register on the current fire.
  assign rd_idx = state_q == ST_IDLE ? a_idx : idx_q + AW'(beat_q) + AW'(1);
  assign wr_idx = state_q == ST_IDLE ? a_idx : idx_q + AW'(beat_q);
  assign we = !reset && a_fire && !auto_in_a_bits_corrupt
           && (state_q == ST_IDLE ? is_put && !deny_now : !den_q);
  tl_responder_mem #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
    .clk(clock), .rd_idx_i(rd_idx), .rd_data_o(rd_data), .we_i(we),
    .wr_idx_i(wr_idx), .wmask_i(auto_in_a_bits_mask), .wdata_i(auto_in_a_bits_data)
  );
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    op_d    = op_q;
    size_d  = size_q;
    src_d   = src_q;
    den_d   = den_q;
    cor_d   = cor_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: if (a_fire) begin
        src_d  = auto_in_a_bits_source;
        size_d = auto_in_a_bits_size;
        idx_d  = a_idx;
        den_d  = deny_now;
        last_d = last_beat(auto_in_a_bits_size);
        beat_d = 3'd0;
        data_d = '0;
        cor_d  = 1'b0;
        if (is_put) begin
          op_d    = D_ACCESS_ACK;
          state_d = last_d == 3'd0 ? ST_RESP : ST_PUT;
          valid_d = last_d == 3'd0;
          beat_d  = last_d == 3'd0 ? 3'd0 : 3'd1;
        end else if (is_hint) begin
          op_d    = D_HINT_ACK;
          state_d = ST_RESP;
          valid_d = 1'b1;
        end else begin
          op_d    = D_ACCESS_ACK_DATA;
          state_d = ST_GET;
          valid_d = 1'b1;
          data_d  = deny_now ? '0 : rd_data;
          cor_d   = deny_now;
        end
      end
      ST_GET: if (d_fire) begin
        state_d = beat_q == last_q ? ST_IDLE : ST_GET;
        valid_d = beat_q != last_q;
        beat_d  = beat_q == last_q ? 3'd0 : beat_q + 3'd1;
        data_d  = den_q ? '0 : rd_data;
      end
      ST_PUT: if (a_fire) begin
        state_d = beat_q == last_q ? ST_RESP : ST_PUT;
        valid_d = beat_q == last_q;
        beat_d  = beat_q == last_q ? 3'd0 : beat_q + 3'd1;
      end
      ST_RESP: if (d_fire) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      op_q    <= '0;
      size_q  <= '0;
      src_q   <= '0;
      den_q   <= 1'b0;
      cor_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      size_q  <= size_d;
      src_q   <= src_d;
      den_q   <= den_d;
      cor_q   <= cor_d;
      data_q  <= data_d;
    end
  end
  assign auto_in_d_valid        = valid_q;
  assign auto_in_d_bits_opcode  = op_q;
  assign auto_in_d_bits_param   = 2'd0;
  assign auto_in_d_bits_size    = size_q;
  assign auto_in_d_bits_source  = src_q;
  assign auto_in_d_bits_sink    = 1'b0;
  assign auto_in_d_bits_denied  = den_q;
  assign auto_in_d_bits_data    = data_q;
  assign auto_in_d_bits_corrupt = cor_q;
endmodule

// File: doc/tl_ram_responder.md
TL_RAM_RESPONDER -- requirements
Module: tl_ram_responder

Interface
REQ-001 Parameters SHALL be:
- BASE_ADDR, default 31'h0800_0000, byte base of the responder window.
- DEPTH_WORDS, default 32, number of 64-bit storage words (power of 2).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  sole clock.
- reset  in  1  sync active-high reset.
- auto_in_a_ready  out  1  A accept.
- auto_in_a_valid  in  1  A request valid.
- auto_in_a_bits_opcode  in  3  A opcode.
- auto_in_a_bits_param  in  3  ignored.
- auto_in_a_bits_size  in  3  log2 bytes.
- auto_in_a_bits_source  in  5  requester id.
- auto_in_a_bits_address  in  31  byte address.
- auto_in_a_bits_mask  in  8  byte lanes.
- auto_in_a_bits_data  in  64  put data.
- auto_in_a_bits_corrupt  in  1  put beat poisoned.
- auto_in_d_ready  in  1  D accept.
- auto_in_d_valid  out  1  D response valid.
- auto_in_d_bits_opcode  out  3  D opcode.
- auto_in_d_bits_param  out  2  always 0.
- auto_in_d_bits_size  out  3  echoed size.
- auto_in_d_bits_source  out  5  echoed source.
- auto_in_d_bits_sink  out  1  always 0.
- auto_in_d_bits_denied  out  1  request refused.
- auto_in_d_bits_data  out  64  read data.
- auto_in_d_bits_corrupt  out  1  data invalid.

Function
REQ-004 The A opcodes handled SHALL be PutFullData=0, PutPartialData=1, Get=4 and Hint=5; opcodes 2, 3, 6 and 7 SHALL be treated as Get with denied=1.
REQ-005 The D opcodes SHALL be AccessAck=0 for Put, AccessAckData=1 for Get, and HintAck=2 for Hint.
REQ-006 The state machine SHALL have four states, IDLE, GET, PUT and RESP, with these transitions:
- IDLE: a_ready=1; d_valid=0.
- IDLE, Get A fire -> GET.
- IDLE, Put A fire, single beat -> RESP.
- IDLE, Put A fire, multi-beat -> PUT.
- IDLE, Hint A fire -> RESP.
REQ-007 On every A fire in IDLE, the block SHALL latch source, size and address.
REQ-008 The beat count SHALL be beats = 1 when size<=3, otherwise 2^(size-3); size is limited to 6 (8 beats), and size 7 SHALL be denied.
REQ-009 GET SHALL behave as follows:
- a_ready=0.
- First D beat is valid the cycle after the A fire.
- Each D fire advances the 3-bit beat counter.
- Data of beat k = mem[(addr[log2(DEPTH_WORDS)+2:3] + k) mod DEPTH_WORDS].
- After the last beat fires, the next state is IDLE.
REQ-010 PUT SHALL behave as follows:
- a_ready=1; d_valid=0.
- Each A fire writes one beat, with the beat counter incrementing.
- Fire of the final beat -> RESP.
REQ-011 Write rule: mem byte lane i SHALL be updated only when mask[i]=1, the request is not denied, and a_bits_corrupt=0 for that beat.
REQ-012 RESP SHALL behave as follows:
- a_ready=0; d_valid=1 with the single response.
- D fire -> IDLE.
REQ-013 While d_valid=1 and d_ready=0, all d_bits SHALL stay stable and no state SHALL change.
REQ-014 Denial rules:
- A request SHALL be denied if its address lies outside [BASE_ADDR, BASE_ADDR+8*DEPTH_WORDS).
- A request SHALL be denied if its address is not aligned to 2^size.
- A request SHALL be denied if size=7.
- A denied Get SHALL return all beats with denied=1, corrupt=1, data=0.
- A denied Put SHALL consume all beats, write nothing, and answer AccessAck with denied=1.
REQ-015 The fields of Put beats after the first, other than data, mask and corrupt, SHALL be ignored.
REQ-016 A Put in progress SHALL be reported on D as corrupt=0 regardless of beat corrupt.
REQ-017 Read-after-write: a Get accepted the cycle after a Put's D fire SHALL return the new data.
REQ-018 The block SHALL accept at most one outstanding transaction and SHALL not overlap A and D traffic of different requests.
REQ-019 The D output fields SHALL be registered; no combinational path from a_* to d_* is permitted.

Reset
REQ-020 Reset SHALL apply the following values:
- State -> IDLE; beat counter = 0.
- d_valid=0; all d_bits=0.
- a_ready=1 from the first cycle after reset deasserts.
REQ-021 Reset mid-burst SHALL abandon the transaction with no D response; a partially written Put SHALL keep the beats already written.
REQ-022 Memory contents SHALL NOT be reset.

Structure
REQ-023 The TileLink A/D opcode constants, field widths (address 31, source 5, data 64) and state encoding SHALL live in a shared package, tl_pkg.
REQ-024 Storage SHALL be a separate sub-module, tl_responder_mem: DEPTH_WORDS x 64, one combinational-read port and one byte-masked synchronous write port.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- PutFull size=3 at addr 0x0800_0010, data 0x1122334455667788, mask 0xFF -> AccessAck, denied=0; then Get size=3 at the same addr -> AccessAckData with data 0x1122334455667788, d_valid one cycle after A fire.
- PutPartial mask 0x0F, data 0xFFFFFFFF_AAAAAAAA over that word, then Get -> data 0x11223344AAAAAAAA.
- Get size=6 at 0x0800_0000 with d_ready toggled 1,0,1 -> 8 beats, word indices 0..7 in order, bits stable while stalled, a_ready=0 until the last fire.
- Get at 0x0800_0100 (out of range) and Get size=3 at 0x0800_0004 (misaligned) -> denied=1, corrupt=1, data=0, memory unchanged.
- Hint (opcode 5) -> HintAck (opcode 2); opcode 2 -> AccessAckData with denied=1.
- Reset asserted during beat 3 of an 8-beat Put -> no D response; next cycle state IDLE, a_ready=1, beats 0-2 written.
